md_sched: RTL and testbench

Multi-cycle multiply/divide controller for the five-stage pipeline. Accepts mult/multu/div/divu/mthi/mtlo from the E stage, holds operands, and counts out a fixed latency before committing HI/LO. Generates the stall request the D-stage hazard logic needs while the unit is occupied. Owns the HI/LO architectural registers.

---
 rtl/md_sched_if.sv | 23 ++
 rtl/md_sched.sv | 129 ++++++++++++
 tb/tb_md_sched.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/md_sched_if.sv
// Multiply/divide unit handshake between the E/D pipeline stages and md_sched.
// Pipeline side is the master; md_sched is the slave and owns busy/stall/HI/LO.
interface md_sched_if;
    logic [2:0]  e_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_md;
    logic        start;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output e_op, e_rs, e_rt, d_md,
        input  start, busy, stall_req, hi, lo
    );

    modport slave (
        input  e_op, e_rs, e_rt, d_md,
        output start, busy, stall_req, hi, lo
    );
endinterface

// File: rtl/md_sched.sv
// Multi-cycle mult/div controller owning HI/LO: commits MULT_CYCLES/DIV_CYCLES after issue, mthi/mtlo next cycle.
// No backpressure on E; stall_req holds any D-stage md instruction while an op is starting or busy.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_sched_if.slave  md
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    op_q;
    logic [31:0]   rs_q;
    logic [31:0]   rt_q;
    logic          busy_q;
    logic [31:0]   hi_q;
    logic [31:0]   lo_q;

    logic          start;
    logic          is_mul;
    logic          is_div;

    // Result datapath works only from latched operands so E can move on.
    logic [63:0]   prod_s;
    logic [63:0]   prod_u;
    logic [31:0]   a_mag, b_mag, q_mag, r_mag;
    logic [31:0]   q_s, r_s, q_u, r_u;
    logic          div_zero;

    assign is_mul = (md.e_op == OP_MULT) || (md.e_op == OP_MULTU);
    assign is_div = (md.e_op == OP_DIV)  || (md.e_op == OP_DIVU);
    assign start  = (state == IDLE) && (is_mul || is_div);

    assign md.start     = start;
    assign md.busy      = busy_q;
    assign md.stall_req = md.d_md & (start | busy_q);
    assign md.hi        = hi_q;
    assign md.lo        = lo_q;

    assign prod_s   = {{32{rs_q[31]}}, rs_q} * {{32{rt_q[31]}}, rt_q};
    assign prod_u   = {32'd0, rs_q} * {32'd0, rt_q};
    assign div_zero = (rt_q == 32'd0);

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        a_mag = rs_q[31] ? (~rs_q + 32'd1) : rs_q;
        b_mag = rt_q[31] ? (~rt_q + 32'd1) : rt_q;
        q_mag = 32'd0;
        r_mag = 32'd0;
        q_u   = 32'd0;
        r_u   = 32'd0;
        if (!div_zero) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
            q_u   = rs_q / rt_q;
            r_u   = rs_q % rt_q;
        end
        q_s = (rs_q[31] ^ rt_q[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s = rs_q[31] ? (~r_mag + 32'd1) : r_mag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= 3'd0;
            rs_q   <= 32'd0;
            rt_q   <= 32'd0;
            busy_q <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= md.e_op;
                        rs_q   <= md.e_rs;
                        rt_q   <= md.e_rt;
                        cnt    <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else if (md.e_op == OP_MTHI) begin
                        hi_q <= md.e_rs;
                    end else if (md.e_op == OP_MTLO) begin
                        lo_q <= md.e_rs;
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                        case (op_q)
                            OP_MULT:  {hi_q, lo_q} <= prod_s;
                            OP_MULTU: {hi_q, lo_q} <= prod_u;
                            OP_DIV: begin
                                if (!div_zero) begin
                                    lo_q <= q_s;
                                    hi_q <= r_s;
                                end
                            end
                            OP_DIVU: begin
                                if (!div_zero) begin
                                    lo_q <= q_u;
                                    hi_q <= r_u;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: directed cases plus random ops against a 64-bit arithmetic model of HI/LO.
module tb_md_sched;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [31:0] mhi;
    logic [31:0] mlo;

    md_sched_if bus ();

    md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Architectural HI/LO result of one op, straight from integer arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] ohi, input logic [31:0] olo,
                         output logic [31:0] nhi, output logic [31:0] nlo);
        longint     a, b, q, r;
        logic [63:0] p;
        nhi = ohi;
        nlo = olo;
        case (op)
            3'd1: begin
                a = longint'($signed(rs));
                b = longint'($signed(rt));
                p = 64'(a * b);
                nhi = p[63:32];
                nlo = p[31:0];
            end
            3'd2: begin
                p = {32'd0, rs} * {32'd0, rt};
                nhi = p[63:32];
                nlo = p[31:0];
            end
            3'd3: if (rt != 0) begin
                a = longint'($signed(rs));
                b = longint'($signed(rt));
                q = a / b;
                r = a % b;
                nlo = q[31:0];
                nhi = r[31:0];
            end
            3'd4: if (rt != 0) begin
                nlo = rs / rt;
                nhi = rs % rt;
            end
            3'd5: nhi = rs;
            3'd6: nlo = rs;
            default: ;
        endcase
    endtask

    // Called at posedge+1 of the issue cycle; returns in the cycle busy falls.
    task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic dmd);
        logic [31:0] nhi, nlo;
        int n;
        n = (op <= 3'd2) ? MULT_N : DIV_N;
        model(op, rs, rt, mhi, mlo, nhi, nlo);
        bus.e_op = op;
        bus.e_rs = rs;
        bus.e_rt = rt;
        bus.d_md = dmd;
        #1;
        chk("issue_start", 32'(bus.start), 32'd1);
        chk("issue_stall", 32'(bus.stall_req), 32'(dmd));
        chk("issue_busy", 32'(bus.busy), 32'd0);
        for (int i = 1; i <= n; i++) begin
            next();
            bus.e_op = 3'd0;
            bus.e_rs = $urandom;
            bus.e_rt = $urandom;
            #1;
            chk("run_busy", 32'(bus.busy), 32'd1);
            chk("run_start", 32'(bus.start), 32'd0);
            chk("run_stall", 32'(bus.stall_req), 32'(dmd));
            chk("run_hi_hold", bus.hi, mhi);
            chk("run_lo_hold", bus.lo, mlo);
        end
        next();
        #1;
        mhi = nhi;
        mlo = nlo;
        chk("done_busy", 32'(bus.busy), 32'd0);
        chk("done_stall", 32'(bus.stall_req), 32'd0);
        chk("done_hi", bus.hi, mhi);
        chk("done_lo", bus.lo, mlo);
    endtask

    task automatic mt_op(input logic [2:0] op, input logic [31:0] val, input logic dmd);
        logic [31:0] nhi, nlo;
        model(op, val, 32'd0, mhi, mlo, nhi, nlo);
        bus.e_op = op;
        bus.e_rs = val;
        bus.e_rt = $urandom;
        bus.d_md = dmd;
        #1;
        chk("mt_start", 32'(bus.start), 32'd0);
        chk("mt_stall", 32'(bus.stall_req), 32'd0);
        next();
        bus.e_op = 3'd0;
        bus.e_rs = $urandom;
        #1;
        mhi = nhi;
        mlo = nlo;
        chk("mt_busy", 32'(bus.busy), 32'd0);
        chk("mt_hi", bus.hi, mhi);
        chk("mt_lo", bus.lo, mlo);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] rs, rt;
        total = 0;
        bad   = 0;
        mhi   = 32'd0;
        mlo   = 32'd0;
        reset = 1'b1;
        bus.e_op = 3'd0;
        bus.e_rs = 32'd0;
        bus.e_rt = 32'd0;
        bus.d_md = 1'b0;
        repeat (3) next();
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_start", 32'(bus.start), 32'd0);

        mt_op(3'd5, 32'h12345678, 1'b1);
        mt_op(3'd6, 32'h9ABCDEF0, 1'b1);
        chk("mthi_const", bus.hi, 32'h12345678);
        chk("mtlo_const", bus.lo, 32'h9ABCDEF0);

        run_op(3'd1, 32'hFFFFFFFE, 32'h00000003, 1'b1);
        chk("mult_hi_const", bus.hi, 32'hFFFFFFFF);
        chk("mult_lo_const", bus.lo, 32'hFFFFFFFA);
        run_op(3'd2, 32'hFFFFFFFE, 32'h00000003, 1'b0);
        chk("multu_hi_const", bus.hi, 32'h00000002);
        chk("multu_lo_const", bus.lo, 32'hFFFFFFFA);

        next();
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        chk("div_lo_const", bus.lo, 32'hFFFFFFFD);
        chk("div_hi_const", bus.hi, 32'hFFFFFFFF);
        mt_op(3'd5, 32'd1, 1'b0);
        mt_op(3'd6, 32'd2, 1'b0);
        run_op(3'd3, 32'd12345, 32'd0, 1'b1);
        chk("div0_hi_const", bus.hi, 32'd1);
        chk("div0_lo_const", bus.lo, 32'd2);
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("ovf_lo_const", bus.lo, 32'h80000000);
        chk("ovf_hi_const", bus.hi, 32'd0);

        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom_range(1, 6));
            rs = $urandom;
            rt = $urandom;
            if ($urandom_range(0, 5) == 0) rt = 32'd0;
            else if ($urandom_range(0, 2) == 0) rt = 32'($urandom_range(0, 8)) - 32'd4;
            if (op <= 3'd4) run_op(op, rs, rt, 1'($urandom_range(0, 1)));
            else mt_op(op, rs, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) next();
        end

        mt_op(3'd5, 32'hDEADBEEF, 1'b0);
        bus.e_op = 3'd4;
        bus.e_rs = 32'd1000;
        bus.e_rt = 32'd7;
        next();
        bus.e_op = 3'd0;
        repeat (3) next();
        chk("abort_busy_pre", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        next();
        reset = 1'b0;
        #1;
        mhi = 32'd0;
        mlo = 32'd0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        repeat (DIV_N) next();
        chk("abort_nocommit_hi", bus.hi, 32'd0);
        chk("abort_nocommit_lo", bus.lo, 32'd0);
        run_op(3'd2, 32'd3, 32'd4, 1'b1);
        chk("post_multu_lo", bus.lo, 32'h0000000C);
        chk("post_multu_hi", bus.hi, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
